axi_dma_wburst: RTL and testbench

//  Downstream stage of the DMA write aligner: takes aligned native write beats plus burst length
//  and issues AXI4 write bursts on AW/W/B. Splits any burst crossing a 4KB boundary.

---
 rtl/axi_dma_wburst_pkg.sv | 24 ++
 rtl/axi_dma_wburst_4k_split.sv | 24 ++
 rtl/axi_dma_wburst.sv | 170 +++++++++++++++++
 tb/tb_axi_dma_wburst.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_wburst_pkg.sv
// Shared AXI field widths, protocol codes and FSM state encoding for the DMA write-burst stage.
package axi_dma_wburst_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;
    localparam int LEN1_W      = AXI_LEN_W + 1;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } wb_state_t;

    function automatic logic [AXI_SIZE_W-1:0] axi_size_code(input int data_w);
        return AXI_SIZE_W'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_dma_wburst_4k_split.sv
// Combinational burst sizing: chunk = min(remaining beats, beats left before the next 4KB edge).
module axi_4k_split
    import axi_dma_wburst_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic [11:0]       addr_lo,
    input  logic [LEN1_W-1:0] rem,
    output logic [LEN1_W-1:0] chunk
);

    localparam int SHIFT = $clog2(DATA_W / 8);

    logic [12:0] to_edge;

    assign to_edge = (13'd4096 - {1'b0, addr_lo}) >> SHIFT;

    always_comb begin
        chunk = rem;
        if (to_edge < 13'(rem))
            chunk = to_edge[LEN1_W-1:0];
    end

endmodule

// File: rtl/axi_dma_wburst.sv
// AXI4 write-burst issuer with 4KB splitting and one burst in flight.
// Optional statistics counters are enabled by defining AXI_DMA_WSTAT_EN.
module axi_dma_wburst
    import axi_dma_wburst_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int AXI_ID_W = 1
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   dma_w_valid,
    input  logic [ADDR_W-1:0]      dma_w_addr,
    input  logic [DATA_W-1:0]      dma_w_wdata,
    input  logic [DATA_W/8-1:0]    dma_w_wstrb,
    input  logic [AXI_LEN_W-1:0]   dma_w_len,
    output logic                   dma_w_ready,
    output logic [AXI_ID_W-1:0]    m_axi_awid,
    output logic [ADDR_W-1:0]      m_axi_awaddr,
    output logic [AXI_LEN_W-1:0]   m_axi_awlen,
    output logic [AXI_SIZE_W-1:0]  m_axi_awsize,
    output logic [AXI_BURST_W-1:0] m_axi_awburst,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [DATA_W-1:0]      m_axi_wdata,
    output logic [DATA_W/8-1:0]    m_axi_wstrb,
    output logic                   m_axi_wlast,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [AXI_ID_W-1:0]    m_axi_bid,
    input  logic [AXI_RESP_W-1:0]  m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    output logic                   busy,
    output logic                   done,
    output logic                   error
`ifdef AXI_DMA_WSTAT_EN
    ,
    output logic [31:0]            stat_beats,
    output logic [15:0]            stat_bursts
`endif
);

    localparam int SHIFT = $clog2(DATA_W / 8);

    wb_state_t         state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN1_W-1:0] rem_q, cnt_q, chunk, chunk_m1;
    logic              aw_fire, w_fire, last_beat, done_set, err_set;
    logic              unused_bid;

    axi_4k_split #(.DATA_W(DATA_W)) u_split (
        .addr_lo (addr_q[11:0]),
        .rem     (rem_q),
        .chunk   (chunk)
    );

    assign chunk_m1      = chunk - LEN1_W'(1);
    assign last_beat     = (cnt_q == chunk_m1);
    assign aw_fire       = m_axi_awvalid & m_axi_awready;
    assign w_fire        = m_axi_wvalid & m_axi_wready;
    assign done_set      = (state == ST_B) && m_axi_bvalid && (rem_q == '0);
    assign err_set       = (state == ST_B) && m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY);
    assign busy          = (state != ST_IDLE);
    assign unused_bid    = ^m_axi_bid;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = chunk_m1[AXI_LEN_W-1:0];
    assign m_axi_awsize  = axi_size_code(DATA_W);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wdata   = dma_w_wdata;
    assign m_axi_wstrb   = dma_w_wstrb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        dma_w_ready   = 1'b0;
        case (state)
            ST_IDLE: if (dma_w_valid) state_nx = ST_AW;
            ST_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_nx = ST_W;
            end
            // W channel is a zero-latency pass-through of the upstream handshake
            ST_W: begin
                m_axi_wvalid = dma_w_valid;
                dma_w_ready  = m_axi_wready;
                m_axi_wlast  = last_beat;
                if (dma_w_valid && m_axi_wready && last_beat) state_nx = ST_B;
            end
            ST_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_nx = (rem_q == '0) ? ST_IDLE : ST_AW;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (dma_w_valid) begin
                    addr_q <= dma_w_addr;
                    rem_q  <= LEN1_W'(dma_w_len) + LEN1_W'(1);
                    cnt_q  <= '0;
                end
                ST_AW: if (aw_fire) cnt_q <= '0;
                // Advance the request past this chunk once its final beat is accepted
                ST_W: if (w_fire) begin
                    if (last_beat) begin
                        rem_q  <= rem_q - chunk;
                        addr_q <= addr_q + (ADDR_W'(chunk) << SHIFT);
                        cnt_q  <= '0;
                    end else begin
                        cnt_q  <= cnt_q + LEN1_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A failing response in the same cycle as clear keeps error set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done <= done_set;
            if (err_set)
                error <= 1'b1;
            else if (clear)
                error <= 1'b0;
        end
    end

`ifdef AXI_DMA_WSTAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_beats  <= '0;
            stat_bursts <= '0;
        end else if (clear) begin
            stat_beats  <= '0;
            stat_bursts <= '0;
        end else begin
            if (w_fire)  stat_beats  <= stat_beats + 32'd1;
            if (aw_fire) stat_bursts <= stat_bursts + 16'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_axi_dma_wburst.sv
// Randomized self-checking bench for axi_dma_wburst against a 4KB-split burst planning model.
module tb_axi_dma_wburst;
    import axi_dma_wburst_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 1;

    logic              clk, rst, clear;
    logic              dma_w_valid, dma_w_ready;
    logic [31:0]       dma_w_addr, dma_w_wdata;
    logic [3:0]        dma_w_wstrb;
    logic [7:0]        dma_w_len;
    logic [ID_W-1:0]   m_axi_awid, m_axi_bid;
    logic [31:0]       m_axi_awaddr, m_axi_wdata;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst, m_axi_bresp;
    logic              m_axi_awvalid, m_axi_awready;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic              m_axi_bvalid, m_axi_bready;
    logic              busy, done, error;

    int checks = 0;
    int errors = 0;
    bit model_error = 1'b0;

    axi_dma_wburst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .dma_w_valid(dma_w_valid), .dma_w_addr(dma_w_addr), .dma_w_wdata(dma_w_wdata),
        .dma_w_wstrb(dma_w_wstrb), .dma_w_len(dma_w_len), .dma_w_ready(dma_w_ready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference plan: cut [addr, addr + 4*(len+1)) at every 4KB edge
    task automatic plan(input logic [31:0] addr, input int len,
                        output logic [31:0] baddr[$], output int blen[$]);
        logic [31:0] a;
        int rem, room, c;
        baddr = {};
        blen  = {};
        a   = addr;
        rem = len + 1;
        while (rem > 0) begin
            room = (4096 - int'(a % 4096)) / 4;
            c    = (rem < room) ? rem : room;
            baddr.push_back(a);
            blen.push_back(c - 1);
            a   = a + 32'(c * 4);
            rem = rem - c;
        end
    endtask

    task automatic idle_inputs();
        dma_w_valid   = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        clear         = 1'b0;
    endtask

    // mode 0: always valid/ready; mode 1: wready every other cycle, random valid gaps
    task automatic run_request(input logic [31:0] addr, input int len, input int mode,
                               input int bad_burst, input bit clear_at_b, input int abort_beat);
        logic [31:0] baddr[$];
        int          blen[$];
        logic [31:0] wd[$];
        logic [3:0]  ws[$];
        int total, idx, rdy, beats, cyc, wait_n;
        bit v, r, bad;
        plan(addr, len, baddr, blen);
        total = len + 1;
        for (int i = 0; i < total; i++) begin
            wd.push_back($urandom);
            ws.push_back(4'($urandom_range(0, 15)));
        end
        idx = 0;
        rdy = 0;
        dma_w_valid = 1'b1;
        dma_w_addr  = addr;
        dma_w_len   = 8'(len);
        dma_w_wdata = wd[0];
        dma_w_wstrb = ws[0];
        #1;
        chk("idle_ready", dma_w_ready, 0);
        chk("idle_busy", busy, 0);
        step();
        for (int k = 0; k < baddr.size(); k++) begin
            wait_n = $urandom_range(0, 2);
            for (int d = 0; d <= wait_n; d++) begin
                m_axi_awready = (d == wait_n);
                #1;
                chk("awvalid", m_axi_awvalid, 1);
                chk("awaddr", m_axi_awaddr, baddr[k]);
                chk("awlen", m_axi_awlen, blen[k]);
                chk("awsize", m_axi_awsize, 2);
                chk("awburst", m_axi_awburst, 1);
                chk("awid", m_axi_awid, 0);
                chk("aw_no_wvalid", m_axi_wvalid, 0);
                chk("aw_ready", dma_w_ready, 0);
                chk("aw_done", done, 0);
                chk("aw_busy", busy, 1);
                step();
            end
            m_axi_awready = 1'b0;
            beats = 0;
            cyc   = 0;
            while (beats < blen[k] + 1 && cyc < 4000) begin
                v = (mode == 0) ? 1'b1 : (($urandom % 3) != 0);
                r = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
                dma_w_valid  = v;
                m_axi_wready = r;
                dma_w_wdata  = wd[idx];
                dma_w_wstrb  = ws[idx];
                #1;
                chk("wvalid", m_axi_wvalid, v);
                chk("w_ready", dma_w_ready, r);
                chk("wdata", m_axi_wdata, wd[idx]);
                chk("wstrb", m_axi_wstrb, ws[idx]);
                chk("wlast", m_axi_wlast, (beats == blen[k]));
                if (dma_w_ready) rdy++;
                if (idx == abort_beat) return;
                if (v && r) begin
                    beats++;
                    idx++;
                end
                cyc++;
                step();
            end
            chk("w_beats", beats, blen[k] + 1);
            m_axi_wready = 1'b0;
            dma_w_valid  = 1'b0;
            wait_n = $urandom_range(0, 2);
            for (int d = 0; d <= wait_n; d++) begin
                bad          = (k == bad_burst) && (d == wait_n);
                m_axi_bvalid = (d == wait_n);
                m_axi_bresp  = bad ? 2'b10 : 2'b00;
                clear        = clear_at_b && (d == wait_n);
                #1;
                chk("bready", m_axi_bready, 1);
                chk("b_no_awvalid", m_axi_awvalid, 0);
                chk("b_no_wvalid", m_axi_wvalid, 0);
                step();
                if (bad) model_error = 1'b1;
                else if (clear) model_error = 1'b0;
            end
            idle_inputs();
        end
        #1;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("error_flag", error, model_error);
        if (mode == 0) chk("ready_cycles", rdy, total);
        step();
        chk("done_cleared", done, 0);
    endtask

    initial begin
        logic [31:0] a;
        int n;
        $display("[TB] start");
        rst = 1'b0;
        dma_w_addr  = '0;
        dma_w_wdata = '0;
        dma_w_wstrb = '0;
        dma_w_len   = '0;
        m_axi_bid   = '0;
        idle_inputs();
        step();
        step();
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_ready", dma_w_ready, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        rst = 1'b1;
        step();

        run_request(32'h0000_0100, 3, 0, -1, 1'b0, -1);
        run_request(32'h0000_0FF8, 7, 0, -1, 1'b0, -1);
        run_request(32'h0000_2A40, 0, 0, -1, 1'b0, -1);
        run_request(32'h0000_3000, 255, 0, -1, 1'b0, -1);
        run_request(32'h0000_0F00, 63, 0, -1, 1'b0, -1);
        run_request(32'h0000_0200, 7, 1, -1, 1'b0, -1);

        run_request(32'h0000_0400, 5, 0, 0, 1'b0, -1);
        run_request(32'h0000_0500, 2, 1, -1, 1'b0, -1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_error = 1'b0;
        chk("clear_error", error, 0);

        run_request(32'h0000_1FFC, 4, 0, 1, 1'b1, -1);
        run_request(32'h0000_0600, 1, 0, -1, 1'b1, -1);

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1)
                a = (32'($urandom_range(1, 4)) << 12) - (32'($urandom_range(1, 64)) << 2);
            else
                a = $urandom & 32'h0000_7FFC;
            n = $urandom_range(0, 255);
            run_request(a, n, int'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? 0 : -1, 1'b0, -1);
        end

        run_request(32'h0000_0800, 7, 0, -1, 1'b0, 1);
        rst = 1'b0;
        #1;
        chk("arst_awvalid", m_axi_awvalid, 0);
        chk("arst_wvalid", m_axi_wvalid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", dma_w_ready, 0);
        chk("arst_error", error, 0);
        model_error = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b1;
        step();
        run_request(32'h0000_0FF0, 9, 1, -1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
